// File: rtl/rgmii_rx_framer_pkg.sv
// Shared constants and FSM encoding for the RGMII receive framer.
package rgmii_rx_framer_pkg;

    localparam logic [7:0] ETH_PRE = 8'h55;
    localparam logic [7:0] ETH_SFD = 8'hD5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_DROP     = 2'd3
    } state_t;

endpackage

// File: rtl/rgmii_rx_framer_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {WIDTH{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: strips preamble/SFD, streams payload bytes on an
// AXI-Stream-like port, tracks in-band link status and frame/error counts.
module rgmii_rx_framer
    import rgmii_rx_framer_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           rxd_q1,
    input  logic [3:0]           rxd_q2,
    input  logic                 rx_ctl_q1,
    input  logic                 rx_ctl_q2,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic                 link_up,
    output logic [1:0]           link_speed,
    output logic                 full_duplex,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    logic [7:0] stg_data_q, stg_data_d;
    logic       stg_dv_q, stg_dv_d;
    logic       stg_er_q, stg_er_d;

    state_t     state_q, state_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       hold_v_q, hold_v_d;
    logic       err_seen_q, err_seen_d;

    logic [7:0] tdata_q, tdata_d;
    logic       tvalid_q, tvalid_d;
    logic       tlast_q, tlast_d;
    logic       tuser_q, tuser_d;

    logic       link_up_q, link_up_d;
    logic [1:0] link_speed_q, link_speed_d;
    logic       full_duplex_q, full_duplex_d;

    logic       good_inc, err_inc;

    always_comb begin
        stg_data_d = {rxd_q2, rxd_q1};
        stg_dv_d   = rx_ctl_q1;
        stg_er_d   = rx_ctl_q1 ^ rx_ctl_q2;
    end

    always_comb begin
        state_d       = state_q;
        hold_data_d   = hold_data_q;
        hold_v_d      = hold_v_q;
        err_seen_d    = err_seen_q;
        tdata_d       = 8'h00;
        tvalid_d      = 1'b0;
        tlast_d       = 1'b0;
        tuser_d       = 1'b0;
        link_up_d     = link_up_q;
        link_speed_d  = link_speed_q;
        full_duplex_d = full_duplex_q;
        good_inc      = 1'b0;
        err_inc       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (stg_dv_q) begin
                    if (stg_data_q == ETH_PRE) begin
                        state_d = ST_PREAMBLE;
                    end else begin
                        state_d = ST_DROP;
                        err_inc = 1'b1;
                    end
                end else if (!stg_er_q) begin
                    // Inter-frame gap carries link status in the data nibbles
                    link_up_d     = stg_data_q[0];
                    link_speed_d  = stg_data_q[2:1];
                    full_duplex_d = stg_data_q[3];
                end
            end
            ST_PREAMBLE: begin
                if (!stg_dv_q) begin
                    state_d = ST_IDLE;
                end else if (stg_data_q == ETH_SFD) begin
                    state_d    = ST_PAYLOAD;
                    err_seen_d = 1'b0;
                    hold_v_d   = 1'b0;
                end else if (stg_data_q != ETH_PRE) begin
                    state_d = ST_DROP;
                    err_inc = 1'b1;
                end
            end
            ST_PAYLOAD: begin
                if (stg_dv_q) begin
                    // One-byte delay so the final byte can carry tlast
                    hold_data_d = stg_data_q;
                    hold_v_d    = 1'b1;
                    if (stg_er_q) err_seen_d = 1'b1;
                    if (hold_v_q) begin
                        tvalid_d = 1'b1;
                        tdata_d  = hold_data_q;
                    end
                end else begin
                    state_d  = ST_IDLE;
                    hold_v_d = 1'b0;
                    if (hold_v_q) begin
                        tvalid_d = 1'b1;
                        tdata_d  = hold_data_q;
                        tlast_d  = 1'b1;
                        tuser_d  = err_seen_q;
                        good_inc = !err_seen_q;
                        err_inc  = err_seen_q;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (!stg_dv_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_data_q    <= 8'h00;
            stg_dv_q      <= 1'b0;
            stg_er_q      <= 1'b0;
            state_q       <= ST_IDLE;
            hold_data_q   <= 8'h00;
            hold_v_q      <= 1'b0;
            err_seen_q    <= 1'b0;
            tdata_q       <= 8'h00;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tuser_q       <= 1'b0;
            link_up_q     <= 1'b0;
            link_speed_q  <= 2'b00;
            full_duplex_q <= 1'b0;
        end else begin
            stg_data_q    <= stg_data_d;
            stg_dv_q      <= stg_dv_d;
            stg_er_q      <= stg_er_d;
            state_q       <= state_d;
            hold_data_q   <= hold_data_d;
            hold_v_q      <= hold_v_d;
            err_seen_q    <= err_seen_d;
            tdata_q       <= tdata_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            tuser_q       <= tuser_d;
            link_up_q     <= link_up_d;
            link_speed_q  <= link_speed_d;
            full_duplex_q <= full_duplex_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_frame_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (good_inc),
        .cnt   (frame_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .cnt   (err_cnt)
    );

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign link_up       = link_up_q;
    assign link_speed    = link_speed_q;
    assign full_duplex   = full_duplex_q;

endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Directed bench for rgmii_rx_framer: default-width instance plus a
// CNT_WIDTH=2 instance on the same inputs for counter saturation.
module tb_rgmii_rx_framer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] rxd_q1, rxd_q2;
    logic       rx_ctl_q1, rx_ctl_q2;

    logic [7:0]  tdata;
    logic        tvalid, tlast, tuser, link_up, full_duplex;
    logic [1:0]  link_speed;
    logic [15:0] frame_cnt, err_cnt;

    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tlast, s_tuser, s_link_up, s_full_duplex;
    logic [1:0]  s_link_speed;
    logic [1:0]  s_frame_cnt, s_err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] idle_b = 8'h00;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       u;
        int         c;
    } beat_t;
    beat_t beats[$];

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (rst_n && tvalid)
            beats.push_back('{d: tdata, l: tlast, u: tuser, c: cyc});

    rgmii_rx_framer dut (
        .clk(clk), .rst_n(rst_n), .rxd_q1(rxd_q1), .rxd_q2(rxd_q2),
        .rx_ctl_q1(rx_ctl_q1), .rx_ctl_q2(rx_ctl_q2),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast),
        .m_axis_tuser(tuser), .link_up(link_up), .link_speed(link_speed),
        .full_duplex(full_duplex), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    rgmii_rx_framer #(.CNT_WIDTH(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .rxd_q1(rxd_q1), .rxd_q2(rxd_q2),
        .rx_ctl_q1(rx_ctl_q1), .rx_ctl_q2(rx_ctl_q2),
        .m_axis_tdata(s_tdata), .m_axis_tvalid(s_tvalid), .m_axis_tlast(s_tlast),
        .m_axis_tuser(s_tuser), .link_up(s_link_up), .link_speed(s_link_speed),
        .full_duplex(s_full_duplex), .frame_cnt(s_frame_cnt), .err_cnt(s_err_cnt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic dv, input logic er);
        rxd_q1    = b[3:0];
        rxd_q2    = b[7:4];
        rx_ctl_q1 = dv;
        rx_ctl_q2 = dv ^ er;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(idle_b, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int n, input int er_idx,
                              output int t_first, output int t_last);
        for (int i = 0; i < 7; i++) send(8'h55, 1'b1, 1'b0);
        send(8'hD5, 1'b1, 1'b0);
        t_first = cyc;
        t_last  = cyc;
        for (int i = 0; i < n; i++) begin
            t_last = cyc;
            send(8'(i + 1), 1'b1, (i == er_idx));
        end
        idle(6);
    endtask

    task automatic check_frame(input string tag, input int n, input int exp_user,
                               input int t_first, input int t_last);
        int bad_d, bad_l, nb;
        bad_d = 0;
        bad_l = 0;
        nb = beats.size();
        chk({tag, " beats"}, nb, n);
        for (int i = 0; i < nb; i++) begin
            if (beats[i].d !== 8'(i + 1)) bad_d++;
            if (beats[i].l !== (i == n - 1)) bad_l++;
        end
        chk({tag, " tdata mismatches"}, bad_d, 0);
        chk({tag, " tlast mismatches"}, bad_l, 0);
        chk({tag, " tuser on tlast"}, (nb > 0) ? int'(beats[nb-1].u) : -1, exp_user);
        chk({tag, " first-beat cycle"}, (nb > 0) ? beats[0].c : -1, t_first + 3);
        chk({tag, " last-beat cycle"}, (nb > 0) ? beats[nb-1].c : -1, t_last + 3);
        beats.delete();
    endtask

    initial begin
        int tf, tl;
        rst_n = 1'b0;
        rxd_q1 = 4'h0; rxd_q2 = 4'h0; rx_ctl_q1 = 1'b0; rx_ctl_q2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset tvalid", tvalid, 0);
        chk("reset tdata", tdata, 0);
        chk("reset tlast", tlast, 0);
        chk("reset frame_cnt", frame_cnt, 0);
        chk("reset err_cnt", err_cnt, 0);
        chk("reset link", {link_up, link_speed, full_duplex}, 0);
        rst_n = 1'b1;
        idle(4);

        // Clean 64-byte frame
        send_frame(64, -1, tf, tl);
        check_frame("good", 64, 0, tf, tl);
        chk("good frame_cnt", frame_cnt, 1);
        chk("good err_cnt", err_cnt, 0);

        // Same frame with RX_ER on the tenth payload byte
        send_frame(64, 9, tf, tl);
        check_frame("er", 64, 1, tf, tl);
        chk("er frame_cnt", frame_cnt, 1);
        chk("er err_cnt", err_cnt, 1);

        // In-band status latch, then hold while er=1
        idle_b = 8'h0D;
        idle(3);
        chk("status link_up", link_up, 1);
        chk("status speed", link_speed, 2);
        chk("status duplex", full_duplex, 1);
        for (int i = 0; i < 3; i++) send(8'h00, 1'b0, 1'b1);
        chk("status hold on er", {link_up, link_speed, full_duplex}, 4'hD);

        // Broken preamble goes to DROP
        send(8'h55, 1'b1, 1'b0);
        send(8'h55, 1'b1, 1'b0);
        send(8'hA3, 1'b1, 1'b0);
        send(8'h10, 1'b1, 1'b0);
        send(8'h11, 1'b1, 1'b0);
        idle(5);
        chk("drop beats", beats.size(), 0);
        chk("drop err_cnt", err_cnt, 2);
        send_frame(64, -1, tf, tl);
        check_frame("after drop", 64, 0, tf, tl);
        chk("after drop frame_cnt", frame_cnt, 2);

        // SFD immediately followed by end of frame
        send(8'h55, 1'b1, 1'b0);
        send(8'hD5, 1'b1, 1'b0);
        idle(5);
        chk("empty beats", beats.size(), 0);
        chk("empty err_cnt", err_cnt, 3);
        chk("empty frame_cnt", frame_cnt, 2);

        // Reset pulse in the middle of a payload
        for (int i = 0; i < 7; i++) send(8'h55, 1'b1, 1'b0);
        send(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) send(8'h20 + 8'(i), 1'b1, 1'b0);
        #1;
        chk("pre-reset tvalid", tvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("async reset tvalid", tvalid, 0);
        chk("async reset tdata", tdata, 0);
        chk("async reset link_up", link_up, 0);
        chk("async reset err_cnt", err_cnt, 0);
        beats.delete();
        send(8'h2A, 1'b1, 1'b0);
        send(8'h2B, 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) send(8'h30 + 8'(i), 1'b1, 1'b0);
        idle(5);
        chk("post-reset beats", beats.size(), 0);
        chk("post-reset err_cnt", err_cnt, 1);
        chk("post-reset frame_cnt", frame_cnt, 0);

        // Five short good frames: narrow counter saturates
        for (int f = 0; f < 5; f++) begin
            send_frame(4, -1, tf, tl);
            check_frame("short", 4, 0, tf, tl);
        end
        chk("wide frame_cnt", frame_cnt, 5);
        chk("narrow frame_cnt saturated", s_frame_cnt, 3);
        chk("narrow err_cnt", s_err_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgmii_rx_framer.md
RGMII_RX_FRAMER -- requirements
Module: rgmii_rx_framer

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the frame and error counters.
REQ-002 Port clk, input, 1: single receive clock, 125 MHz, the same clock that drives the upstream input DDR stage.
REQ-003 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 Port rxd_q1, input, 4: rising-edge nibble from the DDR stage, forming byte bits [3:0].
REQ-005 Port rxd_q2, input, 4: falling-edge nibble from the DDR stage, forming byte bits [7:4].
REQ-006 Port rx_ctl_q1, input, 1: RX_CTL sampled on the rising edge, equal to RX_DV.
REQ-007 Port rx_ctl_q2, input, 1: RX_CTL sampled on the falling edge, equal to RX_DV xor RX_ER.
REQ-008 Port m_axis_tdata, output, 8: payload byte.
REQ-009 Port m_axis_tvalid, output, 1: byte valid; the port has no tready and the block does not accept backpressure.
REQ-010 Port m_axis_tlast, output, 1: last byte of the frame.
REQ-011 Port m_axis_tuser, output, 1: bad-frame flag, qualified by tlast.
REQ-012 Ports link_up (1), link_speed (2) and full_duplex (1), outputs: RGMII in-band status.
REQ-013 Ports frame_cnt and err_cnt, outputs, CNT_WIDTH each: good-frame count and bad-event count.

Function
REQ-014 Input stage register: byte = {rxd_q2, rxd_q1}, dv = rx_ctl_q1, er = rx_ctl_q1 ^ rx_ctl_q2; the stage is registered every clk cycle.
REQ-015 The FSM states SHALL be IDLE, PREAMBLE, PAYLOAD and DROP, evaluated on the stage-register outputs.
REQ-016 IDLE transitions: dv=1 and byte=0x55 -> PREAMBLE; dv=1 and any other byte -> DROP.
REQ-017 IDLE in-band status: when dv=0 and er=0, latch link_up=byte[0], link_speed=byte[2:1], full_duplex=byte[3]; in every other state, and whenever er=1, the status outputs hold.
REQ-018 PREAMBLE transitions: dv=1 and 0x55 -> stay; dv=1 and 0xD5 -> PAYLOAD with err_seen cleared; dv=1 and any other byte -> DROP; dv=0 -> IDLE with no output and no count.
REQ-019 PAYLOAD: each dv=1 byte is written to a one-byte hold register (hold_v=1); if hold_v was already 1, the previous held byte is emitted with tvalid=1 and tlast=0.
REQ-020 PAYLOAD: er=1 with dv=1 sets err_seen.
REQ-021 PAYLOAD end of frame: dv=0 with hold_v=1 emits the held byte with tlast=1 and tuser=err_seen, then the FSM goes to IDLE.
REQ-022 PAYLOAD empty frame: dv=0 with hold_v=0 (SFD directly followed by end of frame) emits nothing, increments err_cnt, and goes to IDLE.
REQ-023 DROP: entry increments err_cnt once; the FSM stays in DROP until dv=0, then goes to IDLE; DROP emits no output.
REQ-024 Latency: a byte present on the inputs in cycle c appears on m_axis_tdata in cycle c+3, including the last byte of the frame.
REQ-025 m_axis_tvalid is a registered pulse of one cycle per byte; tdata, tlast and tuser are don't-care when tvalid=0 but are driven to 0.
REQ-026 frame_cnt increments on tlast with tuser=0.
REQ-027 err_cnt increments on tlast with tuser=1, on DROP entry, and on an empty frame; at most one err_cnt increment occurs per cycle.
REQ-028 Both counters saturate at all-ones and never wrap.
REQ-029 er=1 on the final byte of a frame sets tuser=1 on that same tlast beat.

Reset
REQ-030 rst_n=0 SHALL asynchronously force: FSM=IDLE; hold_v, err_seen and the stage register to 0; all AXI outputs to 0; link_up=0, link_speed=2'b00, full_duplex=0; both counters to 0.
REQ-031 Reset asserted mid-frame aborts the frame without emitting tlast; after release, a frame still in progress (dv=1 with a non-preamble byte) goes to DROP and is counted in err_cnt.

Structure
REQ-032 The shared header holds the constants ETH_PRE=8'h55 and ETH_SFD=8'hD5 and the FSM state encodings.
REQ-033 One sub-module, sat_counter (parameter WIDTH, input inc), is instantiated twice for frame_cnt and err_cnt.
REQ-034 There are no vendor primitives; the block is target-independent.

Verification
REQ-035 Scenario: 7x 0x55, 0xD5, then payload 0x01..0x40 (64 bytes), dv falling -> 64 tvalid beats, tdata 0x01..0x40, tlast on 0x40, tuser=0, frame_cnt=1, first beat 3 cycles after 0x01.
REQ-036 Scenario: same frame with er=1 on byte 10 -> 64 beats, tuser=1 on tlast, err_cnt=1, frame_cnt=0.
REQ-037 Scenario: dv=0, er=0, byte=0x0D -> link_up=1, link_speed=2'b10, full_duplex=1; then dv=0, er=1 -> status unchanged.
REQ-038 Scenario: 0x55, 0x55, 0xA3, ... -> no tvalid, err_cnt=1, next good frame is received normally.
REQ-039 Scenario: 0x55, 0xD5, dv=0 -> no tvalid, err_cnt=1; separately, rst_n pulsed low mid-payload -> outputs 0 immediately, no tlast, trailing bytes give err_cnt=1.
REQ-040 Scenario: CNT_WIDTH=2 with 5 good frames -> frame_cnt saturates at 3.
